// File: rtl/ws_tile_feeder_if.sv
// Job, weight/input stream and array-pin bundle for ws_tile_feeder.
// The feeder takes the slave view; the job source plus array side take the master view.
interface ws_tile_feeder_if #(
  parameter int unsigned rows      = 16,
  parameter int unsigned cols      = 16,
  parameter int unsigned ip_width  = 8,
  parameter int unsigned op_width  = 32,
  parameter int unsigned cnt_width = 16
);
  logic                      start;
  logic [cnt_width-1:0]      num_vecs;
  logic [cols*op_width-1:0]  bias_vec;
  logic                      w_valid;
  logic                      w_ready;
  logic [cols*ip_width-1:0]  w_data;
  logic                      x_valid;
  logic                      x_ready;
  logic [rows*ip_width-1:0]  x_data;
  logic                      arr_en;
  logic                      arr_clr;
  logic [cols*ip_width-1:0]  arr_weight_matrix;
  logic [rows*ip_width-1:0]  arr_input_matrix;
  logic [cols*op_width-1:0]  arr_psum_init_vec;
  logic                      arr_compute_done;
  logic                      busy;
  logic                      done;
  logic [31:0]               job_cycles;

  modport master (
    output start, num_vecs, bias_vec, w_valid, w_data, x_valid, x_data,
           arr_compute_done,
    input  w_ready, x_ready, arr_en, arr_clr, arr_weight_matrix,
           arr_input_matrix, arr_psum_init_vec, busy, done, job_cycles
  );

  modport slave (
    input  start, num_vecs, bias_vec, w_valid, w_data, x_valid, x_data,
           arr_compute_done,
    output w_ready, x_ready, arr_en, arr_clr, arr_weight_matrix,
           arr_input_matrix, arr_psum_init_vec, busy, done, job_cycles
  );
endinterface

// File: rtl/ws_tile_feeder.sv
// Tile-job sequencer for the weight-stationary array: loads weight rows, streams
// input vectors with the captured bias, then waits for a fresh compute_done edge.
module ws_tile_feeder #(
  parameter int unsigned rows      = 16,
  parameter int unsigned cols      = 16,
  parameter int unsigned ip_width  = 8,
  parameter int unsigned op_width  = 32,
  parameter int unsigned cnt_width = 16
) (
  input  logic             clk,
  input  logic             rst,
  ws_tile_feeder_if.slave  bus
);
  localparam int unsigned WW = cols * ip_width;
  localparam int unsigned XW = rows * ip_width;
  localparam int unsigned BW = cols * op_width;
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);
  localparam logic [cnt_width-1:0] LAST_ROW = cnt_width'(rows - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM_X,
    DRAIN,
    FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [cnt_width-1:0] beat_cnt_q, beat_cnt_d;
  logic [cnt_width-1:0] num_vecs_q, num_vecs_d;
  logic [BW-1:0]        bias_q, bias_d;
  logic [31:0]          job_cycles_q, job_cycles_d;
  logic                 cd_q;

  logic                 arr_en_q, arr_en_d;
  logic                 arr_clr_q, arr_clr_d;
  logic [WW-1:0]        arr_w_q, arr_w_d;
  logic [XW-1:0]        arr_x_q, arr_x_d;
  logic [BW-1:0]        arr_p_q, arr_p_d;

  logic                 w_ready, x_ready;
  logic                 w_fire, x_fire, cd_rise;

  assign w_fire  = bus.w_valid & w_ready;
  assign x_fire  = bus.x_valid & x_ready;
  // Only a rising edge counts, so a level held over from earlier is never taken as completion.
  assign cd_rise = bus.arr_compute_done & ~cd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      num_vecs_q   <= '0;
      bias_q       <= '0;
      job_cycles_q <= '0;
      cd_q         <= 1'b0;
      arr_en_q     <= 1'b0;
      arr_clr_q    <= 1'b0;
      arr_w_q      <= '0;
      arr_x_q      <= '0;
      arr_p_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      num_vecs_q   <= num_vecs_d;
      bias_q       <= bias_d;
      job_cycles_q <= job_cycles_d;
      cd_q         <= bus.arr_compute_done;
      arr_en_q     <= arr_en_d;
      arr_clr_q    <= arr_clr_d;
      arr_w_q      <= arr_w_d;
      arr_x_q      <= arr_x_d;
      arr_p_q      <= arr_p_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    num_vecs_d   = num_vecs_q;
    bias_d       = bias_q;
    job_cycles_d = job_cycles_q;
    arr_en_d     = 1'b0;
    arr_clr_d    = 1'b0;
    arr_w_d      = '0;
    arr_x_d      = '0;
    arr_p_d      = '0;

    // The start cycle is counted by loading 1; FINISH is the last counted cycle.
    if (state_q != IDLE && job_cycles_q != '1) begin
      job_cycles_d = job_cycles_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_vecs_d   = bus.num_vecs;
          bias_d       = bus.bias_vec;
          job_cycles_d = 32'd1;
          beat_cnt_d   = '0;
          state_d      = LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          arr_en_d  = 1'b1;
          arr_clr_d = 1'b1;
          arr_w_d   = bus.w_data;
          if (beat_cnt_q == LAST_ROW) begin
            beat_cnt_d = '0;
            state_d    = (num_vecs_q != '0) ? STREAM_X : FINISH;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end
      STREAM_X: begin
        if (x_fire) begin
          arr_en_d = 1'b1;
          arr_x_d  = bus.x_data;
          arr_p_d  = bias_q;
          if (beat_cnt_q == num_vecs_q - CNT_ONE) begin
            beat_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        if (cd_rise) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    w_ready  = 1'b0;
    x_ready  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      LOAD_W: begin
        w_ready  = 1'b1;
        bus.busy = 1'b1;
      end
      STREAM_X: begin
        x_ready  = 1'b1;
        bus.busy = 1'b1;
      end
      DRAIN: begin
        bus.busy = 1'b1;
      end
      FINISH: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.w_ready           = w_ready;
  assign bus.x_ready           = x_ready;
  assign bus.job_cycles        = job_cycles_q;
  assign bus.arr_en            = arr_en_q;
  assign bus.arr_clr           = arr_clr_q;
  assign bus.arr_weight_matrix = arr_w_q;
  assign bus.arr_input_matrix  = arr_x_q;
  assign bus.arr_psum_init_vec = arr_p_q;
endmodule

// File: tb/tb_ws_tile_feeder.sv
// Bench for ws_tile_feeder (4x4 array): random job traffic checked cycle by
// cycle against a job-level model of the expected array pins and job status.
module tb_ws_tile_feeder;
  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned WW = C * IW;
  localparam int unsigned XW = R * IW;
  localparam int unsigned BW = C * OW;
  localparam int unsigned PW = 2 + WW + XW + BW;

  logic clk;
  logic rst;

  ws_tile_feeder_if #(.rows(R), .cols(C), .ip_width(IW), .op_width(OW), .cnt_width(CW)) bus_if ();

  ws_tile_feeder #(.rows(R), .cols(C), .ip_width(IW), .op_width(OW), .cnt_width(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          exp_en, exp_clr;
  logic [WW-1:0] exp_w;
  logic [XW-1:0] exp_x;
  logic [BW-1:0] exp_p;
  logic [31:0]   last_jc;

  task automatic idle_inputs();
    bus_if.start            = 1'b0;
    bus_if.num_vecs         = '0;
    bus_if.bias_vec         = '0;
    bus_if.w_valid          = 1'b0;
    bus_if.w_data           = '0;
    bus_if.x_valid          = 1'b0;
    bus_if.x_data           = '0;
    bus_if.arr_compute_done = 1'b0;
  endtask

  // Drives one job starting in the current IDLE cycle (no negedge pending on entry or exit).
  // vmode: 0 always valid, 1 alternating starting with 1, 2 random.
  task automatic run_job(input string tag, input int nv, input int wmode, input int xmode,
                         input logic [BW-1:0] bias, input bit stale_cd, input int cd_gap,
                         input int rst_at_x, input bit fin_start);
    int wi, xi, drain_n, drop_k, k;
    bit tog_w, tog_x, prev_cd, cur_cd, fin, v, finished, in_drain;
    logic [PW-1:0] pa, pe;
    logic [35:0]   sa, se;
    wi = 0; xi = 0; drain_n = 0; drop_k = -1;
    tog_w = 1'b1; tog_x = 1'b1; prev_cd = 1'b0; fin = 1'b0; finished = 1'b0;
    for (k = 0; k < 400 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      pa = {bus_if.arr_en, bus_if.arr_clr, bus_if.arr_weight_matrix,
            bus_if.arr_input_matrix, bus_if.arr_psum_init_vec};
      pe = {exp_en, exp_clr, exp_w, exp_x, exp_p};
      sa = {bus_if.w_ready, bus_if.x_ready, bus_if.busy, bus_if.done, bus_if.job_cycles};
      checks++;
      if (pa !== pe) begin
        errors++;
        $display("FAIL %s arr_pins k=%0d got %h want %h", tag, k, pa, pe);
      end
      exp_en = 1'b0; exp_clr = 1'b0; exp_w = '0; exp_x = '0; exp_p = '0;
      bus_if.w_valid  = 1'($urandom);
      bus_if.w_data   = WW'($urandom);
      bus_if.x_valid  = 1'($urandom);
      bus_if.x_data   = XW'($urandom);
      bus_if.start    = ($urandom_range(0, 3) == 0);
      bus_if.num_vecs = CW'($urandom);
      bus_if.bias_vec = BW'({$urandom(), $urandom(), $urandom(), $urandom()});
      in_drain = (k > 0) && (wi >= R) && (xi >= nv) && (nv > 0) && !fin;
      if (stale_cd) cur_cd = (drop_k < 0 || k < drop_k) ? 1'b1 : (k >= drop_k + 10);
      else          cur_cd = in_drain && (drain_n >= cd_gap);

      if (k == 0) begin
        se = {4'b0000, last_jc};
        bus_if.start    = 1'b1;
        bus_if.num_vecs = CW'(nv);
        bus_if.bias_vec = bias;
      end else if (wi < R) begin
        se = {4'b1010, 32'(k)};
        v = (wmode == 0) ? 1'b1 : (wmode == 1) ? tog_w : 1'($urandom);
        tog_w = ~tog_w;
        bus_if.w_valid = v;
        if (v) begin
          exp_en = 1'b1; exp_clr = 1'b1; exp_w = bus_if.w_data;
          wi++;
        end
      end else if (xi < nv) begin
        se = {4'b0110, 32'(k)};
        if (rst_at_x >= 0 && xi == rst_at_x) begin
          checks++;
          if (sa !== se) begin
            errors++;
            $display("FAIL %s status k=%0d got %h want %h", tag, k, sa, se);
          end
          idle_inputs();
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          pa = {bus_if.arr_en, bus_if.arr_clr, bus_if.arr_weight_matrix,
                bus_if.arr_input_matrix, bus_if.arr_psum_init_vec};
          sa = {bus_if.w_ready, bus_if.x_ready, bus_if.busy, bus_if.done, bus_if.job_cycles};
          checks++;
          if ({pa, sa} !== '0) begin
            errors++;
            $display("FAIL %s after_reset got %h want 0", tag, {pa, sa});
          end
          for (int i = 0; i < 6; i++) begin
            bus_if.arr_compute_done = (i == 2);
            @(negedge clk);
            checks++;
            if ({bus_if.busy, bus_if.done, bus_if.arr_en} !== 3'b000) begin
              errors++;
              $display("FAIL %s post_reset_quiet got %b want 000", tag,
                       {bus_if.busy, bus_if.done, bus_if.arr_en});
            end
          end
          idle_inputs();
          last_jc = '0;
          return;
        end
        v = (xmode == 0) ? 1'b1 : (xmode == 1) ? tog_x : 1'($urandom);
        tog_x = ~tog_x;
        bus_if.x_valid = v;
        if (v) begin
          exp_en = 1'b1; exp_x = bus_if.x_data; exp_p = bias;
          xi++;
          if (stale_cd && xi == 1) drop_k = k + 1;
        end
      end else if (in_drain) begin
        se = {4'b0010, 32'(k)};
        if (cur_cd && !prev_cd) fin = 1'b1;
        drain_n++;
      end else begin
        se = {4'b0001, 32'(k)};
        bus_if.start = fin_start;
        cur_cd = 1'b0;
        finished = 1'b1;
      end
      bus_if.arr_compute_done = cur_cd;
      prev_cd = cur_cd;
      checks++;
      if (sa !== se) begin
        errors++;
        $display("FAIL %s status k=%0d got %h want %h", tag, k, sa, se);
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got no done want done within 400 cycles", tag);
    end
    @(negedge clk);
    pa = {bus_if.arr_en, bus_if.arr_clr, bus_if.arr_weight_matrix,
          bus_if.arr_input_matrix, bus_if.arr_psum_init_vec};
    sa = {bus_if.w_ready, bus_if.x_ready, bus_if.busy, bus_if.done, bus_if.job_cycles};
    se = {4'b0000, 32'(k)};
    checks++;
    if ({pa, sa} !== {{PW{1'b0}}, se}) begin
      errors++;
      $display("FAIL %s post_finish got %h/%h want 0/%h", tag, pa, sa, se);
    end
    last_jc = 32'(k);
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [PW+35:0] all_out;
    idle_inputs();
    bus_if.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    all_out = {bus_if.arr_en, bus_if.arr_clr, bus_if.arr_weight_matrix, bus_if.arr_input_matrix,
               bus_if.arr_psum_init_vec, bus_if.w_ready, bus_if.x_ready, bus_if.busy,
               bus_if.done, bus_if.job_cycles};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", all_out);
    end
    idle_inputs();
    rst = 1'b0;
    exp_en = 1'b0; exp_clr = 1'b0; exp_w = '0; exp_x = '0; exp_p = '0;
    last_jc = '0;
  endtask

  task automatic test_back_to_back();
    run_job("b2b_full", 3, 0, 0, '0, 1'b0, 2, -1, 1'b1);
    run_job("b2b_next", 2, 0, 0, BW'({$urandom(), $urandom(), $urandom(), $urandom()}),
            1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_weight_bubbles();
    run_job("w_toggle", 2, 1, 0, BW'({$urandom(), $urandom()}), 1'b0, 1, -1, 1'b0);
  endtask

  task automatic test_zero_vecs();
    run_job("zero_vecs", 0, 0, 0, '1, 1'b0, 0, -1, 1'b0);
    checks++;
    if (last_jc !== 32'd6) begin
      errors++;
      $display("FAIL zero_vecs_job_cycles got %0d want 6", last_jc);
    end
  endtask

  task automatic test_stale_done();
    run_job("stale_done", 3, 0, 0, BW'($urandom()), 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_bias_capture();
    logic [BW-1:0] b;
    int lanes [4];
    lanes = '{5, -7, 0, 100};
    for (int j = 0; j < 4; j++) b[j*OW +: OW] = OW'(lanes[j]);
    run_job("bias_capture", 4, 0, 1, b, 1'b0, 3, -1, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    run_job("rst_mid", 4, 0, 0, BW'($urandom()), 1'b0, 0, 1, 1'b0);
    run_job("after_rst", 2, 2, 2, BW'({$urandom(), $urandom()}), 1'b0, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_job("random", int'($urandom_range(1, 6)), 2, 2,
              BW'({$urandom(), $urandom(), $urandom(), $urandom()}),
              1'b0, int'($urandom_range(0, 5)), -1, 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_weight_bubbles();
    test_zero_vecs();
    test_stale_done();
    test_bias_capture();
    test_reset_mid_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws_tile_feeder.md
Name: ws_tile_feeder

Overview:
Upstream sequencer for the weight-stationary systolic array. It accepts one tile job: `rows` weight words, then `num_vecs` input vectors, plus an optional bias vector. It drives the array's en/clr phase pins, weight/input buses and psum-init vector. It then waits for the array's compute_done and reports job completion with a cycle count.

Parameters:
rows, 16, array rows (input vector lanes; number of weight words per load)
cols, 16, array columns (weight word lanes; bias lanes)
ip_width, 8, signed input/weight element width
op_width, 32, psum/bias element width
cnt_width, 16, width of num_vecs and internal beat counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
num_vecs  in  cnt_width  input vectors in job; captured at start
bias_vec  in  cols*op_width  per-column psum init; captured at start
w_valid  in  1  weight word valid
w_ready  out  1  weight word ready
w_data  in  cols*ip_width  one weight row; first accepted word ends in array row rows-1
x_valid  in  1  input vector valid
x_ready  out  1  input vector ready
x_data  in  rows*ip_width  one input vector
arr_en  out  1  array en
arr_clr  out  1  array clr (1 = weight load phase)
arr_weight_matrix  out  cols*ip_width  array weight bus
arr_input_matrix  out  rows*ip_width  array input bus
arr_psum_init_vec  out  cols*op_width  array psum init bus
arr_compute_done  in  1  array compute_done
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse
job_cycles  out  32  cycles from start acceptance to done; held until next start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, including buses and job_cycles. FSM resets to IDLE.
- Reset mid-job: returns to IDLE on the next edge. arr_en/arr_clr drop to 0, and no done pulse is issued.
- All arr_* outputs are registered. A beat accepted on edge N appears on the array pins in cycle N+1 for exactly one cycle.
- FSM states are IDLE, LOAD_W, STREAM_X, DRAIN, FINISH.
- IDLE:
  - busy=0.
  - When start=1: capture num_vecs and bias_vec, clear job_cycles, set busy=1, and go to LOAD_W.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&w_ready beat registers arr_en=1, arr_clr=1, and arr_weight_matrix=w_data. arr_input_matrix and arr_psum_init_vec are 0.
  - A cycle with no beat registers arr_en=0, arr_clr=0 (bubble; the array holds).
  - After the rows-th beat: go to STREAM_X if num_vecs!=0, else go to FINISH.
- STREAM_X:
  - x_ready=1.
  - Each beat registers arr_en=1, arr_clr=0, arr_input_matrix=x_data, and arr_psum_init_vec=captured bias. arr_weight_matrix is 0.
  - A cycle with no beat registers arr_en=0 and zero buses.
  - After the num_vecs-th beat, go to DRAIN.
- DRAIN:
  - arr_en=0.
  - A registered copy of arr_compute_done is kept. Exit only on a 0->1 edge of arr_compute_done, then go to FINISH.
  - A stale 1 left from a prior job or from a mid-stream stall is ignored until it has fallen.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- job_cycles increments every cycle while busy=1, saturating at 0xFFFFFFFF. It stops at FINISH and holds its value.
- w_ready and x_ready are 0 outside their states. Data offered there is not consumed.
- start while busy is ignored.
- start on the same cycle as FINISH is ignored. It is accepted the cycle after, in IDLE.
- w_valid asserted during STREAM_X has no effect. x_valid asserted during LOAD_W has no effect.

Test Plan:
- rows=cols=4, start with num_vecs=3 and bias 0; 4 weight words and 3 vectors, all valid back-to-back -> arr_en high for 7 consecutive cycles (4 with clr=1, then 3 with clr=0); done pulses one cycle after arr_compute_done rises; busy is low after done.
- Weight words W0..W3 with w_valid toggling 1,0,1,0 -> arr_en pattern 1,0,1,0,... with arr_clr matching; arr_weight_matrix equals W0..W3 in order, each one cycle after acceptance.
- num_vecs=0 -> after the 4th weight beat, FSM goes to FINISH with no compute beats and never waits on arr_compute_done; done pulses; job_cycles=6 (start cycle plus 4 loads plus finish).
- arr_compute_done held at 1 at job start, drops after the first compute beat, then rises 10 cycles later -> done issued only after that rise, never on the stale level.
- bias_vec lanes 5,-7,0,100 captured at start, then changed after start -> arr_psum_init_vec shows the captured values on every compute beat and 0 on load and bubble cycles.
- rst asserted for one cycle mid STREAM_X -> the next cycle has all outputs 0 and the FSM in IDLE; no done pulse; a fresh start then completes normally.
